lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store control stage between EX and the MEM data-memory wrapper (word-only, no byte enables).
//  Accepts one byte/half/word load or store per request and word-aligns the address.
//  Performs read-modify-write for sub-word stores, and extracts and sign/zero-extends load data.
//  Flags misaligned or illegal requests without touching memory.
// PARAMETERS
//  WIDTH  32  data/address width; only 32 is supported
// PORTS
//  clk_in           in   1      clock, rising edge
//  rst_n_in         in   1      asynchronous active-low reset
//  req_valid_in     in   1      request valid
//  req_ready_out    out  1      request accepted when valid&ready
//  req_we_in        in   1      1=store, 0=load
//  req_funct3_in    in   3      RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr_in      in   WIDTH  byte address
//  req_wdata_in     in   WIDTH  store data (low bytes used for SB/SH)
//  resp_valid_out   out  1      one-cycle completion pulse
//  resp_rdata_out   out  WIDTH  extended load data (0 for stores and errors)
//  resp_err_out     out  1      misaligned or illegal funct3
//  mem_we_out       out  1      to MEM we_in
//  mem_re_out       out  1      to MEM re_in
//  mem_addr_out     out  WIDTH  to MEM address_in; {addr[WIDTH-1:2],2'b00}
//  mem_wdata_out    out  WIDTH  to MEM data_in
//  mem_rdata_in     in   WIDTH  from MEM data_out; valid the cycle after mem_re_out
// BEHAVIOUR
//  Reset: state=IDLE; req_ready_out=1; all other outputs 0; request registers cleared.
//  Reset mid-operation: mem_we_out/mem_re_out drop immediately (async); the request is abandoned with no response.
//  FSM states: IDLE, READ, WAIT, WRITE, RESP.
//  - IDLE: ready=1. On accept, latch all request fields and route:
//      - error -> RESP;
//      - LW/LB/LH/LBU/LHU/SB/SH -> READ;
//      - SW -> WRITE.
//  - READ: mem_re_out=1 at the latched word address -> WAIT.
//  - WAIT: capture mem_rdata_in into buf. Load -> RESP. Sub-word store -> WRITE.
//  - WRITE: mem_we_out=1. SW writes wdata. SB/SH write buf with the lane at addr[1:0] replaced. -> RESP.
//  - RESP: resp_valid_out=1 for one cycle -> IDLE. req_ready_out is low in every state except IDLE.
//  Latency, accept edge = N:
//  - loads: resp in cycle N+3;
//  - SW: resp in cycle N+2;
//  - SB/SH: resp in cycle N+4;
//  - errors: resp in cycle N+1.
//  Error cases set resp_err_out=1 with no mem_we/re:
//  - LH/LHU/SH with addr[0]!=0;
//  - LW/SW with addr[1:0]!=0;
//  - funct3 011/110/111, or store funct3 >=3'b011.
//  Load extraction: the byte or half is selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
//  resp_rdata_out and resp_err_out are registered and held until the next RESP. Only resp_valid_out qualifies them.
//  mem_addr_out and mem_wdata_out are 0 whenever we and re are both low.
//  Inputs are ignored while ready=0; there is no buffering of a second request.
// CONFIGURATION
//  LSU_BADADDR_EN defined:
//  - adds output badaddr_out [WIDTH], reset 0;
//  - it loads the full faulting req_addr_in in the RESP cycle of any error response;
//  - it is held otherwise.
//  LSU_BADADDR_EN undefined: the port is absent and all other behaviour is identical.
// TESTING
//  Step 1. SW addr 0x10 data 0xDEADBEEF -> we=1, mem_addr=0x10 in N+1; resp N+2 with err=0.
//  Step 2. After step 1, LW 0x10 -> re in N+1; resp N+3 with rdata 0xDEADBEEF.
//  Step 3. SB 0x11 data 0x55 over 0xDEADBEEF -> read, then write 0xDEAD55EF; resp N+4.
//  Step 4. LB 0x13 / LBU 0x13 -> 0xFFFFFFDE / 0x000000DE. LH 0x12 -> 0xFFFFDEAD.
//  Step 5. LW 0x12 -> resp N+1 with err=1, no we/re; with LSU_BADADDR_EN, badaddr=0x12.
//  Step 6. rst_n low during WRITE of SB -> we falls immediately, no resp, ready=1 after release.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake and data-memory bus bundle for lsu_ctrl.
// The slave modport is the LSU's view. The master modport is the EX/memory side's view.
interface lsu_ctrl_if #(parameter int WIDTH = 32);
  logic             req_valid_in;
  logic             req_ready_out;
  logic             req_we_in;
  logic [2:0]       req_funct3_in;
  logic [WIDTH-1:0] req_addr_in;
  logic [WIDTH-1:0] req_wdata_in;
  logic             resp_valid_out;
  logic [WIDTH-1:0] resp_rdata_out;
  logic             resp_err_out;
  logic             mem_we_out;
  logic             mem_re_out;
  logic [WIDTH-1:0] mem_addr_out;
  logic [WIDTH-1:0] mem_wdata_out;
  logic [WIDTH-1:0] mem_rdata_in;

  modport slave (
    input  req_valid_in, req_we_in, req_funct3_in, req_addr_in, req_wdata_in, mem_rdata_in,
    output req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
           mem_we_out, mem_re_out, mem_addr_out, mem_wdata_out
  );

  modport master (
    output req_valid_in, req_we_in, req_funct3_in, req_addr_in, req_wdata_in, mem_rdata_in,
    input  req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
           mem_we_out, mem_re_out, mem_addr_out, mem_wdata_out
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control between EX and a word-only data memory.
// Word-aligns addresses, does read-modify-write for SB/SH, and extends LB/LH/LBU/LHU data.
// Misaligned or illegal requests respond with an error and never touch memory.
// Optional feature: define LSU_BADADDR_EN to add badaddr_out, which captures the faulting address.
module lsu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  lsu_ctrl_if.slave        bus
`ifdef LSU_BADADDR_EN
  ,
  output logic [WIDTH-1:0] badaddr_out
`endif
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

  state_t           state;
  state_t           next_state;

  logic             req_err;
  logic             accept;

  logic             we_q;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] buf_word;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;

  logic [WIDTH-1:0] word_addr;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] load_data;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign accept    = (state == IDLE) && bus.req_valid_in;
  assign word_addr = {addr_q[WIDTH-1:2], 2'b00};

  // Classify the incoming request: misaligned halves/words and unused funct3 codes are errors.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3_in)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = bus.req_addr_in[0];
      3'b010:         req_err = |bus.req_addr_in[1:0];
      default:        req_err = 1'b1;
    endcase
    if (bus.req_we_in && bus.req_funct3_in[2]) begin
      req_err = 1'b1;
    end
  end

  // Pick the addressed byte/half out of the returning memory word and extend it.
  always_comb begin
    byte_sel  = bus.mem_rdata_in[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = addr_q[1] ? bus.mem_rdata_in[31:16] : bus.mem_rdata_in[15:0];
    load_data = '0;
    case (funct3_q)
      3'b000:  load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      3'b010:  load_data = bus.mem_rdata_in;
      3'b100:  load_data = {{(WIDTH-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_data = '0;
    endcase
  end

  // Build the word to store: SW passes data through, SB/SH patch one lane of the word read back.
  always_comb begin
    merged = buf_word;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and bus outputs; memory strobes come straight from state so reset drops them at once.
  always_comb begin
    next_state         = state;
    bus.req_ready_out  = 1'b0;
    bus.mem_re_out     = 1'b0;
    bus.mem_we_out     = 1'b0;
    bus.mem_addr_out   = '0;
    bus.mem_wdata_out  = '0;
    bus.resp_valid_out = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready_out = 1'b1;
        if (bus.req_valid_in) begin
          if (req_err) begin
            next_state = RESP;
          end else if (bus.req_we_in && (bus.req_funct3_in[1:0] == 2'b10)) begin
            next_state = WRITE;
          end else begin
            next_state = READ;
          end
        end
      end
      READ: begin
        bus.mem_re_out   = 1'b1;
        bus.mem_addr_out = word_addr;
        next_state       = WAIT;
      end
      WAIT: begin
        next_state = we_q ? WRITE : RESP;
      end
      WRITE: begin
        bus.mem_we_out    = 1'b1;
        bus.mem_addr_out  = word_addr;
        bus.mem_wdata_out = merged;
        next_state        = RESP;
      end
      RESP: begin
        bus.resp_valid_out = 1'b1;
        next_state         = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the request, capture read data, and set the response registers on the way into RESP.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_word <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we_in;
        funct3_q <= bus.req_funct3_in;
        addr_q   <= bus.req_addr_in;
        wdata_q  <= bus.req_wdata_in;
        if (req_err) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state == WAIT) begin
        buf_word <= bus.mem_rdata_in;
        if (!we_q) begin
          rdata_q <= load_data;
          err_q   <= 1'b0;
        end
      end
      if (state == WRITE) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.resp_rdata_out = rdata_q;
  assign bus.resp_err_out   = err_q;

`ifdef LSU_BADADDR_EN
  // Remember the address of the most recent faulting request; it is visible during its RESP cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      badaddr_out <= '0;
    end else if (accept && req_err) begin
      badaddr_out <= bus.req_addr_in;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector bench for lsu_ctrl with a small word memory model.
module tb_lsu_ctrl;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  lsu_ctrl_if #(.WIDTH(32)) bus ();

`ifdef LSU_BADADDR_EN
  logic [31:0] badaddr;
  logic [31:0] last_bad;
`endif

  lsu_ctrl #(.WIDTH(32)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
`ifdef LSU_BADADDR_EN
    ,
    .badaddr_out (badaddr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: writes on we, read data appears the cycle after re.
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (bus.mem_we_out) mem[bus.mem_addr_out[5:2]] <= bus.mem_wdata_out;
    bus.mem_rdata_in <= bus.mem_re_out ? mem[bus.mem_addr_out[5:2]] : 32'h0;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v, input bit junk);
    int          lat;
    bit          seen;
    bit          saw_re;
    bit          saw_we;
    bit          addr_ok;
    bit          idle_ok;
    bit          ready_ok;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    string       tag;
    tag      = $sformatf("v%0d", idx);
    lat      = 0;
    seen     = 0;
    saw_re   = 0;
    saw_we   = 0;
    addr_ok  = 1;
    idle_ok  = 1;
    ready_ok = 1;
    wd       = 32'h0;
    rd       = 32'h0;
    er       = 1'b0;
    @(negedge clk);
    check_output({tag, "_ready_idle"}, {31'b0, bus.req_ready_out}, 32'd1);
    bus.req_valid_in  = 1'b1;
    bus.req_we_in     = v.we;
    bus.req_funct3_in = v.f3;
    bus.req_addr_in   = v.addr;
    bus.req_wdata_in  = v.wdata;
    @(posedge clk);
    #1;
    if (junk) begin
      bus.req_we_in     = 1'b1;
      bus.req_funct3_in = 3'b010;
      bus.req_addr_in   = 32'h18;
      bus.req_wdata_in  = 32'hBADC0DE0;
    end else begin
      bus.req_valid_in = 1'b0;
    end
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (bus.mem_re_out) begin
        saw_re = 1;
        if (bus.mem_addr_out !== {v.addr[31:2], 2'b00}) addr_ok = 0;
      end
      if (bus.mem_we_out) begin
        saw_we = 1;
        wd = bus.mem_wdata_out;
        if (bus.mem_addr_out !== {v.addr[31:2], 2'b00}) addr_ok = 0;
      end
      if (!bus.mem_re_out && !bus.mem_we_out &&
          (bus.mem_addr_out !== 32'h0 || bus.mem_wdata_out !== 32'h0)) idle_ok = 0;
      if (bus.req_ready_out !== 1'b0) ready_ok = 0;
      if (bus.resp_valid_out === 1'b1) begin
        seen = 1;
        lat  = k;
        rd   = bus.resp_rdata_out;
        er   = bus.resp_err_out;
`ifdef LSU_BADADDR_EN
        if (v.err) last_bad = v.addr;
        check_output({tag, "_badaddr"}, badaddr, last_bad);
`endif
      end
    end
    bus.req_valid_in = 1'b0;
    check_output({tag, "_latency"}, 32'(lat), 32'(v.lat));
    check_output({tag, "_err"}, {31'b0, er}, {31'b0, v.err});
    check_output({tag, "_rdata"}, rd, v.rdata);
    check_output({tag, "_saw_re"}, {31'b0, saw_re}, {31'b0, v.exp_re});
    check_output({tag, "_saw_we"}, {31'b0, saw_we}, {31'b0, v.exp_we});
    if (v.exp_we) check_output({tag, "_wdata"}, wd, v.exp_wdata);
    check_output({tag, "_mem_addr"}, {31'b0, addr_ok}, 32'd1);
    check_output({tag, "_bus_quiet"}, {31'b0, idle_ok}, 32'd1);
    check_output({tag, "_ready_busy"}, {31'b0, ready_ok}, 32'd1);
    @(negedge clk);
    check_output({tag, "_pulse"}, {31'b0, bus.resp_valid_out}, 32'd0);
    check_output({tag, "_held_rdata"}, bus.resp_rdata_out, v.rdata);
    check_output({tag, "_held_err"}, {31'b0, bus.resp_err_out}, {31'b0, v.err});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no end expected end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit got_we;
    bit spurious;
    passed = 0;
    total  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
`ifdef LSU_BADADDR_EN
    last_bad = 32'h0;
`endif

    //           we    f3      addr    wdata          lat err  rdata          re    we    exp_wdata
    vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        3, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 3'b000, 32'h11, 32'h12345655, 4, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDEAD55EF};
    vecs[3]  = '{1'b0, 3'b000, 32'h13, 32'h0,        3, 1'b0, 32'hFFFFFFDE, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 3'b100, 32'h13, 32'h0,        3, 1'b0, 32'h000000DE, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 3'b001, 32'h12, 32'h0,        3, 1'b0, 32'hFFFFDEAD, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 3'b101, 32'h12, 32'h0,        3, 1'b0, 32'h0000DEAD, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'b000, 32'h11, 32'h0,        3, 1'b0, 32'h00000055, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 3'b100, 32'h10, 32'h0,        3, 1'b0, 32'h000000EF, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 3'b010, 32'h12, 32'h0,        1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 3'b010, 32'h14, 32'h89ABCDEF, 2, 1'b0, 32'h0,        1'b0, 1'b1, 32'h89ABCDEF};
    vecs[11] = '{1'b1, 3'b001, 32'h16, 32'hFFFF7E01, 4, 1'b0, 32'h0,        1'b1, 1'b1, 32'h7E01CDEF};
    vecs[12] = '{1'b0, 3'b001, 32'h16, 32'h0,        3, 1'b0, 32'h00007E01, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 3'b001, 32'h14, 32'h0,        3, 1'b0, 32'hFFFFCDEF, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 3'b000, 32'h14, 32'h000000A5, 4, 1'b0, 32'h0,        1'b1, 1'b1, 32'h7E01CDA5};
    vecs[15] = '{1'b0, 3'b010, 32'h14, 32'h0,        3, 1'b0, 32'h7E01CDA5, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 3'b001, 32'h11, 32'h1111,     1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 3'b101, 32'h13, 32'h0,        1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[18] = '{1'b1, 3'b010, 32'h16, 32'h22222222, 1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[19] = '{1'b0, 3'b011, 32'h10, 32'h0,        1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[20] = '{1'b0, 3'b110, 32'h10, 32'h0,        1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[21] = '{1'b0, 3'b111, 32'h10, 32'h0,        1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[22] = '{1'b1, 3'b100, 32'h10, 32'h33333333, 1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[23] = '{1'b1, 3'b101, 32'h12, 32'h44444444, 1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[24] = '{1'b0, 3'b010, 32'h10, 32'h0,        3, 1'b0, 32'hDEAD55EF, 1'b1, 1'b0, 32'h0};
    vecs[25] = '{1'b1, 3'b000, 32'h12, 32'h00000080, 4, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDE8055EF};
    vecs[26] = '{1'b0, 3'b000, 32'h12, 32'h0,        3, 1'b0, 32'hFFFFFF80, 1'b1, 1'b0, 32'h0};
    vecs[27] = '{1'b0, 3'b010, 32'h18, 32'h0,        3, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h0};
    vecs[28] = '{1'b0, 3'b010, 32'h1C, 32'h0,        3, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h0};

    rst_n             = 1'b0;
    bus.req_valid_in  = 1'b0;
    bus.req_we_in     = 1'b0;
    bus.req_funct3_in = 3'b000;
    bus.req_addr_in   = 32'h0;
    bus.req_wdata_in  = 32'h0;
    repeat (2) @(negedge clk);
    check_output("rst_ready", {31'b0, bus.req_ready_out}, 32'd1);
    check_output("rst_resp_valid", {31'b0, bus.resp_valid_out}, 32'd0);
    check_output("rst_rdata", bus.resp_rdata_out, 32'h0);
    check_output("rst_err", {31'b0, bus.resp_err_out}, 32'd0);
    check_output("rst_strobes", {30'b0, bus.mem_we_out, bus.mem_re_out}, 32'd0);
    check_output("rst_mem_addr", bus.mem_addr_out, 32'h0);
    check_output("rst_mem_wdata", bus.mem_wdata_out, 32'h0);
`ifdef LSU_BADADDR_EN
    check_output("rst_badaddr", badaddr, 32'h0);
`endif
    rst_n = 1'b1;

    // Vector 3 keeps a different valid request on the inputs while busy; vector 27 shows it was ignored.
    for (int i = 0; i < 27; i++) apply_stimulus(i, vecs[i], i == 3);

    // Reset in the WRITE cycle of an SB: strobe drops at once, no response, memory untouched.
    @(negedge clk);
    bus.req_valid_in  = 1'b1;
    bus.req_we_in     = 1'b1;
    bus.req_funct3_in = 3'b000;
    bus.req_addr_in   = 32'h1C;
    bus.req_wdata_in  = 32'h00000099;
    @(posedge clk);
    #1;
    bus.req_valid_in = 1'b0;
    got_we = 0;
    for (int k = 0; k < 6 && !got_we; k++) begin
      @(negedge clk);
      if (bus.mem_we_out === 1'b1) got_we = 1;
    end
    check_output("rstseq_reached_write", {31'b0, got_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rstseq_we_drop", {31'b0, bus.mem_we_out}, 32'd0);
    check_output("rstseq_re_low", {31'b0, bus.mem_re_out}, 32'd0);
    check_output("rstseq_addr_zero", bus.mem_addr_out, 32'h0);
    check_output("rstseq_ready", {31'b0, bus.req_ready_out}, 32'd1);
    check_output("rstseq_rdata", bus.resp_rdata_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid_out !== 1'b0 || bus.mem_we_out !== 1'b0) spurious = 1;
    end
    check_output("rstseq_no_resp", {31'b0, spurious}, 32'd0);
    check_output("rstseq_ready_after", {31'b0, bus.req_ready_out}, 32'd1);

    apply_stimulus(27, vecs[27], 1'b0);
    apply_stimulus(28, vecs[28], 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
